bin2rns_seq: RTL

- Sequential binary-to-RNS forward converter; the inverse of the rns2bin decode path.
- Accepts a 19-bit unsigned binary word and produces one-hot residues for the moduli 8, 9, 5, 7, 11, 13 and 17, packed as the rns0 struct.
- Reduction is bit-serial, MSB-first, with BPC bits consumed per cycle.
- Sits on the ingress side of the RNS datapath, with valid/ready handshakes on both sides.

---
 rtl/rns_pkg.sv | 51 +++++
 rtl/bin2rns_seq_if.sv | 36 +++
 rtl/bin2rns_seq_onehot_mod_step.sv | 41 ++++
 rtl/bin2rns_seq.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/rns_pkg.sv
// ---------------------------------------------------------------------------
// rns_pkg
// Shared definitions for the binary-to-RNS ingress path:
//   - moduli constants and their combined product
//   - rns0_t : packed one-hot residue word (x8 is the MSB field, x17 the LSB)
//   - RNS0_ZERO : the one-hot encoding of residue 0 in every field
//   - state_e : converter FSM states
// ---------------------------------------------------------------------------
package rns_pkg;

  localparam int M8  = 8;
  localparam int M9  = 9;
  localparam int M5  = 5;
  localparam int M7  = 7;
  localparam int M11 = 11;
  localparam int M13 = 13;
  localparam int M17 = 17;

  // Product of all moduli; any input width W must satisfy 2**W < MOD_PRODUCT.
  localparam int MOD_PRODUCT = 6126120;

  localparam int W_DEFAULT = 19;

  // Bit k of a field set means the residue for that modulus is k.
  typedef struct packed {
    logic [M8-1:0]  x8;
    logic [M9-1:0]  x9;
    logic [M5-1:0]  x5;
    logic [M7-1:0]  x7;
    logic [M11-1:0] x11;
    logic [M13-1:0] x13;
    logic [M17-1:0] x17;
  } rns0_t;

  localparam rns0_t RNS0_ZERO = '{
    x8:  8'd1,
    x9:  9'd1,
    x5:  5'd1,
    x7:  7'd1,
    x11: 11'd1,
    x13: 13'd1,
    x17: 17'd1
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_e;

endpackage

// File: rtl/bin2rns_seq_if.sv
// ---------------------------------------------------------------------------
// bin2rns_seq_if
// Ingress/egress handshake bundle of the binary-to-RNS converter.
//   in_valid  : source presents x
//   in_ready  : converter can accept a word
//   x         : W-bit unsigned operand
//   out_valid : y holds a complete result
//   out_ready : sink accepts y
//   y         : rns0_t one-hot residue word
// Modports:
//   master : the source/sink environment around the converter
//   slave  : the converter itself
// ---------------------------------------------------------------------------
interface bin2rns_seq_if #(
  parameter int W = rns_pkg::W_DEFAULT
) ();
  import rns_pkg::*;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x;
  logic         out_valid;
  logic         out_ready;
  rns0_t        y;

  modport master (
    output in_valid, x, out_ready,
    input  in_ready, out_valid, y
  );

  modport slave (
    input  in_valid, x, out_ready,
    output in_ready, out_valid, y
  );

endinterface

// File: rtl/bin2rns_seq_onehot_mod_step.sv
// ---------------------------------------------------------------------------
// onehot_mod_step
// Purely combinational one-hot residue update for a single modulus:
//   r_o = onehot((r * 2**BPC + c) mod M)
// where r is the residue encoded in r_i and c is the chunk c_i.
// Ports:
//   r_i : M-bit one-hot current residue
//   c_i : BPC-bit chunk (next bits of the operand, MSB-first)
//   r_o : M-bit one-hot next residue
// For a fixed chunk value the map is a fixed wiring of source bits to
// target bits, so the block is a 2**BPC-way mux of permutations.
// ---------------------------------------------------------------------------
module onehot_mod_step #(
  parameter int M   = 8,
  parameter int BPC = 1
) (
  input  logic [M-1:0]   r_i,
  input  logic [BPC-1:0] c_i,
  output logic [M-1:0]   r_o
);

  localparam int NC = 1 << BPC;

  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    r_o = '0;
    for (int c = 0; c < NC; c++) begin
      if (c_i == BPC'(c)) begin
        // When 2**BPC shares a factor with M several source residues land on
        // the same target; ORing is safe because only one source bit is set.
        for (int k = 0; k < M; k++) begin
          if (r_i[k]) begin
            r_o = r_o | (M'(1) << ((k * NC + c) % M));
          end
        end
      end
    end
  end

endmodule

// File: rtl/bin2rns_seq.sv
// ---------------------------------------------------------------------------
// bin2rns_seq
// Sequential binary-to-RNS forward converter. A W-bit word is reduced
// MSB-first, BPC bits per cycle, into one-hot residues for moduli
// 8, 9, 5, 7, 11, 13, 17, packed as rns0_t.
// Ports:
//   clk        : clock, rising-edge active
//   rst        : asynchronous active-high reset
//   bus        : bin2rns_seq_if.slave (in_valid/in_ready/x, out_valid/out_ready/y)
//   onehot_err : sticky one-hot violation flag (only with BIN2RNS_ONEHOT_CHECK_EN)
// Optional build macro BIN2RNS_ONEHOT_CHECK_EN adds the onehot_err port, its
// sticky checker and a simulation assertion on the one-hot invariant.
// Timing: the accepting edge loads the operand, the following CYC edges each
// consume one chunk, and the last of those enters DONE, so out_valid is seen
// CYC+1 edges after acceptance counting the accepting edge; with out_ready
// held high the next word is accepted CYC+2 edges after the previous one.
// Parameter constraint: 2**W < MOD_PRODUCT, BPC in 1..4.
// ---------------------------------------------------------------------------
module bin2rns_seq
  import rns_pkg::*;
#(
  parameter int W   = W_DEFAULT,
  parameter int BPC = 1
) (
  input  logic         clk,
  input  logic         rst,
  bin2rns_seq_if.slave bus
`ifdef BIN2RNS_ONEHOT_CHECK_EN
  ,
  output logic         onehot_err
`endif
);

  localparam int CYC = (W + BPC - 1) / BPC;
  localparam int SW  = CYC * BPC;          // operand left-padded to whole chunks
  localparam int CW  = $clog2(CYC + 1);

  state_e        state_q, state_d;
  logic [SW-1:0] sh_q, sh_d;
  logic [CW-1:0] cnt_q, cnt_d;
  rns0_t         res_q, res_d;
  rns0_t         res_step;

  logic [BPC-1:0] chunk;
  logic [M8-1:0]  s8;
  logic [M9-1:0]  s9;
  logic [M5-1:0]  s5;
  logic [M7-1:0]  s7;
  logic [M11-1:0] s11;
  logic [M13-1:0] s13;
  logic [M17-1:0] s17;

  assign chunk = sh_q[SW-1 -: BPC];

  onehot_mod_step #(.M(M8),  .BPC(BPC)) u_step8  (.r_i(res_q.x8),  .c_i(chunk), .r_o(s8));
  onehot_mod_step #(.M(M9),  .BPC(BPC)) u_step9  (.r_i(res_q.x9),  .c_i(chunk), .r_o(s9));
  onehot_mod_step #(.M(M5),  .BPC(BPC)) u_step5  (.r_i(res_q.x5),  .c_i(chunk), .r_o(s5));
  onehot_mod_step #(.M(M7),  .BPC(BPC)) u_step7  (.r_i(res_q.x7),  .c_i(chunk), .r_o(s7));
  onehot_mod_step #(.M(M11), .BPC(BPC)) u_step11 (.r_i(res_q.x11), .c_i(chunk), .r_o(s11));
  onehot_mod_step #(.M(M13), .BPC(BPC)) u_step13 (.r_i(res_q.x13), .c_i(chunk), .r_o(s13));
  onehot_mod_step #(.M(M17), .BPC(BPC)) u_step17 (.r_i(res_q.x17), .c_i(chunk), .r_o(s17));

  assign res_step = '{x8: s8, x9: s9, x5: s5, x7: s7, x11: s11, x13: s13, x17: s17};

  // State register. The operand shift register and residues are plain
  // registers (no RAM), so all of them return to known values on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      res_q   <= RNS0_ZERO;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          sh_d    = SW'(bus.x);
          res_d   = RNS0_ZERO;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        res_d = res_step;
        sh_d  = sh_q << BPC;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(CYC - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // y comes straight from the residue registers: no path from x to y.
  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.y         = res_q;

`ifdef BIN2RNS_ONEHOT_CHECK_EN
  logic onehot_bad;
  logic onehot_err_q;

  assign onehot_bad = ($countones(res_q.x8)  != 1) ||
                      ($countones(res_q.x9)  != 1) ||
                      ($countones(res_q.x5)  != 1) ||
                      ($countones(res_q.x7)  != 1) ||
                      ($countones(res_q.x11) != 1) ||
                      ($countones(res_q.x13) != 1) ||
                      ($countones(res_q.x17) != 1);

  // Sticky: only rst clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      onehot_err_q <= 1'b0;
    end else if (onehot_bad) begin
      onehot_err_q <= 1'b1;
    end
  end

  assign onehot_err = onehot_err_q;

  a_onehot : assert property (@(posedge clk) disable iff (rst) !onehot_bad);
`endif

endmodule
